rotate_seq_ctrl: RTL and testbench

- Synthesizable sequencer for the Keccak rho (rotate) datapath and its test-vector file I/O.
- Processes a run of NUM_FILES states. For each state it:
  - requests a 1600-bit state load;
  - steps the rotate unit through all 25 lanes, supplying each lane's rho offset;
  - pulses the file writer with the current file_index.
- Sits between the file reader, the lane-rotate datapath and the file writer.

---
 rtl/rotate_seq_ctrl.sv | 109 ++++++++++
 tb/tb_rotate_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_seq_ctrl.sv
// Sequencer for the Keccak rho datapath: per state it loads a file, walks 25 lanes
// with their rho offsets, then writes the result, for NUM_FILES consecutive indices.
module rotate_seq_ctrl #(
  parameter int NUM_FILES = 8,
  parameter int IDX_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] base_index_i,
  input  logic             read_done_i,
  output logic             read_file_o,
  output logic [4:0]       lane_sel_o,
  output logic [5:0]       rot_amt_o,
  output logic             lane_we_o,
  output logic             write_file_o,
  output logic [IDX_W-1:0] file_index_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_ROT, S_WRITE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       lane_q, lane_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_file;

  // Termination depends only on the run counter so file_index may wrap freely.
  assign last_file = (cnt_q == CNT_W'(NUM_FILES - 1));

  function automatic logic [5:0] rho(input logic [4:0] lane);
    case (lane)
      5'd0:  rho = 6'd0;   5'd1:  rho = 6'd1;   5'd2:  rho = 6'd62;
      5'd3:  rho = 6'd28;  5'd4:  rho = 6'd27;  5'd5:  rho = 6'd36;
      5'd6:  rho = 6'd44;  5'd7:  rho = 6'd6;   5'd8:  rho = 6'd55;
      5'd9:  rho = 6'd20;  5'd10: rho = 6'd3;   5'd11: rho = 6'd10;
      5'd12: rho = 6'd43;  5'd13: rho = 6'd25;  5'd14: rho = 6'd39;
      5'd15: rho = 6'd41;  5'd16: rho = 6'd45;  5'd17: rho = 6'd15;
      5'd18: rho = 6'd21;  5'd19: rho = 6'd8;   5'd20: rho = 6'd18;
      5'd21: rho = 6'd2;   5'd22: rho = 6'd61;  5'd23: rho = 6'd56;
      5'd24: rho = 6'd14;
      default: rho = 6'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_READ;
        idx_d   = base_index_i;
        cnt_d   = '0;
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: if (read_done_i) begin
        state_d = S_ROT;
        lane_d  = '0;
      end
      S_ROT: if (lane_q == 5'd24) begin
        state_d = S_WRITE;
        lane_d  = '0;
      end else begin
        lane_d = lane_q + 5'd1;
      end
      S_WRITE: if (last_file) begin
        state_d = S_DONE;
      end else begin
        state_d = S_READ;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q + IDX_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_file_o  = (state_q == S_READ);
    lane_we_o    = (state_q == S_ROT);
    write_file_o = (state_q == S_WRITE);
    done_o       = (state_q == S_DONE);
    busy_o       = (state_q != S_IDLE);
    lane_sel_o   = lane_q;
    rot_amt_o    = (state_q == S_ROT) ? rho(lane_q) : 6'd0;
    file_index_o = idx_q;
  end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Directed bench for rotate_seq_ctrl: two instances (1-file and 3-file runs) share
// stimulus and are checked every cycle against a lane-position reference model.
module tb_rotate_seq_ctrl;

  localparam int RHO_T [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                                41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  typedef struct packed {
    logic       rd;
    logic [4:0] ls;
    logic [5:0] ra;
    logic       we;
    logic       wr;
    logic [9:0] idx;
    logic       busy;
    logic       done;
  } ov_t;

  typedef struct packed {
    ov_t         o;
    logic [5:0]  pos;   // 0: not walking lanes, 1..25: lane pos-1 shown, 26: write shown
    logic [9:0]  idx;
    logic [10:0] left;
  } ms_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rdone = 1'b0;
  logic [9:0] base = '0;

  logic rf1, we1, wf1, bz1, dn1, rf3, we3, wf3, bz3, dn3;
  logic [4:0] ls1, ls3;
  logic [5:0] ra1, ra3;
  logic [9:0] fi1, fi3;
  ov_t dv [2];
  ms_t ms [2] = '{default: '0};

  int n_chk = 0, n_err = 0;
  bit chk_en = 0;
  int rd_c [2], wr_c [2], dn_c [2], we_c [2];
  int rot_log1 [25];
  int wr_idx1;
  int wr_log [$];

  always #5 clk = ~clk;

  rotate_seq_ctrl #(.NUM_FILES(1), .IDX_W(10)) u1 (
    .clk(clk), .rst(rst), .start_i(start), .base_index_i(base), .read_done_i(rdone),
    .read_file_o(rf1), .lane_sel_o(ls1), .rot_amt_o(ra1), .lane_we_o(we1),
    .write_file_o(wf1), .file_index_o(fi1), .busy_o(bz1), .done_o(dn1));

  rotate_seq_ctrl #(.NUM_FILES(3), .IDX_W(10)) u3 (
    .clk(clk), .rst(rst), .start_i(start), .base_index_i(base), .read_done_i(rdone),
    .read_file_o(rf3), .lane_sel_o(ls3), .rot_amt_o(ra3), .lane_we_o(we3),
    .write_file_o(wf3), .file_index_o(fi3), .busy_o(bz3), .done_o(dn3));

  assign dv[0] = {rf1, ls1, ra1, we1, wf1, fi1, bz1, dn1};
  assign dv[1] = {rf3, ls3, ra3, we3, wf3, fi3, bz3, dn3};

  function automatic ov_t mko(logic rd, logic we, int ls, logic wr, logic dn, logic [9:0] idx);
    ov_t o;
    o.rd = rd; o.we = we; o.ls = 5'(ls); o.ra = we ? 6'(RHO_T[ls]) : 6'd0;
    o.wr = wr; o.done = dn; o.idx = idx; o.busy = 1'b1;
    return o;
  endfunction

  // One clock of the reference behaviour: what the outputs show in the next cycle.
  function automatic ms_t step(ms_t s, int nf, logic r, logic st, logic [9:0] b, logic rd);
    ms_t n = s;
    if (r) return '0;
    if (!s.o.busy) begin
      if (st) begin
        n.idx = b; n.left = 11'(nf); n.pos = '0;
        n.o = mko(1, 0, 0, 0, 0, b);
      end
    end else if (s.o.done) begin
      n.o = '0; n.o.idx = s.idx;
    end else if (s.o.rd) begin
      n.o = mko(0, 0, 0, 0, 0, s.idx);
    end else if (s.pos == 0) begin
      if (rd) begin n.pos = 6'd1; n.o = mko(0, 1, 0, 0, 0, s.idx); end
    end else if (s.pos < 25) begin
      n.pos = s.pos + 6'd1; n.o = mko(0, 1, int'(s.pos), 0, 0, s.idx);
    end else if (s.pos == 25) begin
      n.pos = 6'd26; n.o = mko(0, 0, 0, 1, 0, s.idx);
    end else begin
      n.pos = '0;
      if (s.left == 11'd1) n.o = mko(0, 0, 0, 0, 1, s.idx);
      else begin
        n.left = s.left - 11'd1; n.idx = s.idx + 10'd1;
        n.o = mko(1, 0, 0, 0, 0, n.idx);
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ms[0] <= step(ms[0], 1, rst, start, base, rdone);
    ms[1] <= step(ms[1], 3, rst, start, base, rdone);
  end

  // Advance one cycle, compare both instances with the model and log output events.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (chk_en) begin
        n_chk++;
        if (dv[k] !== ms[k].o) begin
          n_err++;
          $display("FAIL cycle u%0d t=%0t: dut rd=%b ls=%0d ra=%0d we=%b wr=%b idx=%0d busy=%b done=%b | want rd=%b ls=%0d ra=%0d we=%b wr=%b idx=%0d busy=%b done=%b",
                   k, $time, dv[k].rd, dv[k].ls, dv[k].ra, dv[k].we, dv[k].wr, dv[k].idx, dv[k].busy, dv[k].done,
                   ms[k].o.rd, ms[k].o.ls, ms[k].o.ra, ms[k].o.we, ms[k].o.wr, ms[k].o.idx, ms[k].o.busy, ms[k].o.done);
        end
      end
      if (dv[k].rd === 1'b1) rd_c[k]++;
      if (dv[k].wr === 1'b1) begin
        wr_c[k]++;
        if (k == 1) wr_log.push_back(int'(dv[k].idx)); else wr_idx1 = int'(dv[k].idx);
      end
      if (dv[k].done === 1'b1) dn_c[k]++;
      if (dv[k].we === 1'b1) begin
        we_c[k]++;
        if (k == 0 && dv[k].ls < 25) rot_log1[dv[k].ls] = int'(dv[k].ra);
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin rd_c[k] = 0; wr_c[k] = 0; dn_c[k] = 0; we_c[k] = 0; end
    for (int i = 0; i < 25; i++) rot_log1[i] = -1;
    wr_idx1 = -1;
    wr_log.delete();
  endtask

  // sel: 0 read_file, 1 done, 2 lane 12 in ROT, 3 lane 5 in ROT (all on the 3-file instance)
  task automatic wait_cond(int sel, string nm);
    for (int i = 0; i < 500; i++) begin
      case (sel)
        0: if (rf3 === 1'b1) return;
        1: if (dn3 === 1'b1) return;
        2: if (we3 === 1'b1 && ls3 == 5'd12) return;
        default: if (we3 === 1'b1 && ls3 == 5'd5) return;
      endcase
      tick();
    end
    n_chk++; n_err++;
    $display("FAIL timeout %s: got no event, expected one within 500 cycles", nm);
  endtask

  task automatic go(logic [9:0] b);
    base = b; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic serve(int w);
    wait_cond(0, "read_file");
    repeat (w) tick();
    rdone = 1'b1; tick(); rdone = 1'b0;
  endtask

  task automatic finish_run();
    wait_cond(1, "done");
    repeat (3) tick();
  endtask

  initial begin
    clr();
    chk_en = 1;
    tick(); tick();
    rst = 1'b0; tick();
    chk("reset busy", int'(bz3), 0);
    chk("reset read_file", int'(rf3), 0);
    chk("reset file_index", int'(fi3), 0);

    // single-file run and first-read latency
    clr();
    go(10'd5);
    chk("start->read_file", int'(rf1), 1);
    chk("start->busy", int'(bz1), 1);
    serve(1); serve(1); serve(1);
    finish_run();
    chk("u1 lane_we cycles", we_c[0], 25);
    chk("u1 rot lane2", rot_log1[2], 62);
    chk("u1 rot lane7", rot_log1[7], 6);
    chk("u1 rot lane24", rot_log1[24], 14);
    chk("u1 write index", wr_idx1, 5);
    chk("u1 done count", dn_c[0], 1);
    chk("u1 busy after", int'(bz1), 0);
    chk("u3 read count", rd_c[1], 3);

    // index wrap across 1023
    clr();
    go(10'd1022);
    serve(1); serve(2); serve(1);
    finish_run();
    chk("wrap write count", wr_c[1], 3);
    chk("wrap read count", rd_c[1], 3);
    chk("wrap done count", dn_c[1], 1);
    chk("wrap idx0", (wr_log.size() > 0) ? wr_log[0] : -1, 1022);
    chk("wrap idx1", (wr_log.size() > 1) ? wr_log[1] : -1, 1023);
    chk("wrap idx2", (wr_log.size() > 2) ? wr_log[2] : -1, 0);

    // long read wait with a stray start
    clr();
    go(10'd100);
    wait_cond(0, "read_file");
    for (int i = 0; i < 100; i++) begin
      start = (i == 50);
      tick();
    end
    start = 1'b0;
    chk("no lane_we while waiting", we_c[1], 0);
    rdone = 1'b1; tick(); rdone = 1'b0;
    serve(1); serve(1);
    finish_run();
    chk("stray start read count", rd_c[1], 3);
    chk("stray start last idx", (wr_log.size() > 2) ? wr_log[2] : -1, 102);

    // reset in the middle of ROT
    clr();
    go(10'd7);
    serve(1);
    wait_cond(2, "lane 12");
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid-run reset busy", int'(bz3), 0);
    chk("mid-run reset lane_we", int'(we3), 0);
    chk("mid-run reset file_index", int'(fi3), 0);
    clr();
    repeat (30) tick();
    chk("no write after reset", wr_c[1] + wr_c[0], 0);
    go(10'd7);
    serve(1); serve(1); serve(1);
    finish_run();
    chk("rerun first idx", (wr_log.size() > 0) ? wr_log[0] : -1, 7);
    chk("rerun last idx", (wr_log.size() > 2) ? wr_log[2] : -1, 9);

    // stray read_done in IDLE and during ROT
    clr();
    rdone = 1'b1; repeat (3) tick(); rdone = 1'b0;
    chk("read_done in idle", int'(bz3), 0);
    go(10'd0);
    for (int f = 0; f < 3; f++) begin
      serve(1);
      wait_cond(3, "lane 5");
      rdone = 1'b1; tick(); rdone = 1'b0;
    end
    finish_run();
    chk("stray rd lane_we u3", we_c[1], 75);
    chk("stray rd lane_we u1", we_c[0], 25);
    chk("stray rd writes", wr_c[1], 3);
    chk("stray rd done", dn_c[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
